// File: rtl/acc_result_packer_pkg.sv
// Definitions shared by the accumulator adder and its result packer:
// exponent encoding, output formats and the packer FSM states.
package acc_result_packer_pkg;

  localparam int EXP_W       = 8;
  localparam int EXP_BIAS    = 127;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  localparam int FP32_FRAC_W = 23;
  localparam int BF16_FRAC_W = 7;
  localparam int WORD_W      = 32;
  localparam int HALF_W      = 16;

  typedef enum logic {
    FMT_FP32 = 1'b0,
    FMT_BF16 = 1'b1
  } fmt_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_e;

endpackage

// File: rtl/acc_result_packer_if.sv
// Stream bundle between the accumulator drain and the writeback path.
// The slave modport is the packer's view; master is the surrounding logic.
interface acc_result_packer_if
  import acc_result_packer_pkg::*;
#(
  parameter int M_OUT_WIDTH = 26
);

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W-1:0]       in_exp;
  logic [M_OUT_WIDTH-1:0] in_mant;
  logic                   in_fmt;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_W-1:0]      out_data;
  logic                   out_last;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_fmt, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_fmt, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/acc_result_packer_round.sv
// Combinational round-to-nearest-even of an accumulator value to a T-bit
// fraction; overflow (or an Inf input) saturates to infinity.
module acc_round_rne
  import acc_result_packer_pkg::*;
#(
  parameter int M = 26,
  parameter int T = 23
) (
  input  logic [EXP_W-1:0]   exponent,
  input  logic [M-1:0]       mant,
  output logic [EXP_W+T-1:0] result
);

  logic [T-1:0]       keep;
  logic               inc;
  logic [EXP_W+T-1:0] sum;

  generate
    if (M > T) begin : g_round
      logic guard;
      logic sticky;
      assign keep  = mant[M-1 -: T];
      assign guard = mant[M-1-T];
      if (M - T >= 2) begin : g_sticky
        assign sticky = |mant[M-2-T:0];
      end else begin : g_no_sticky
        assign sticky = 1'b0;
      end
      assign inc = guard & (sticky | keep[0]);
    end else if (M == T) begin : g_exact
      assign keep = mant;
      assign inc  = 1'b0;
    end else begin : g_pad
      assign keep = {mant, {(T-M){1'b0}}};
      assign inc  = 1'b0;
    end
  endgenerate

  // The carry out of the fraction lands in the exponent, which covers both
  // mantissa overflow and denormal-to-normal promotion.
  assign sum = {exponent, keep} + {{(EXP_W+T-1){1'b0}}, inc};

  always_comb begin
    result = sum;
    if (sum[EXP_W+T-1 -: EXP_W] == EXP_INF || exponent == EXP_INF) begin
      result = {EXP_INF, {T{1'b0}}};
    end
  end

endmodule

// File: rtl/acc_result_packer.sv
// Rounds finished accumulator values to FP32 or BF16 and packs them into
// 32-bit writeback words, two BF16 results per word.
module acc_result_packer
  import acc_result_packer_pkg::*;
#(
  parameter int M_OUT_WIDTH = 26
) (
  input logic                clk,
  input logic                rst,
  acc_result_packer_if.slave bus
);

  logic [EXP_W+FP32_FRAC_W-1:0] fp32_rnd;
  logic [EXP_W+BF16_FRAC_W-1:0] bf16_rnd;
  logic [WORD_W-1:0]            rounded;
  fmt_e                         in_fmt_e;

  acc_round_rne #(.M(M_OUT_WIDTH), .T(FP32_FRAC_W)) u_round_fp32 (
    .exponent (bus.in_exp),
    .mant     (bus.in_mant),
    .result   (fp32_rnd)
  );

  acc_round_rne #(.M(M_OUT_WIDTH), .T(BF16_FRAC_W)) u_round_bf16 (
    .exponent (bus.in_exp),
    .mant     (bus.in_mant),
    .result   (bf16_rnd)
  );

  assign in_fmt_e = fmt_e'(bus.in_fmt);
  // BF16 values sit in the low half so stage 2 can treat them uniformly.
  assign rounded  = (in_fmt_e == FMT_BF16) ? {16'h0000, bus.in_sign, bf16_rnd}
                                           : {bus.in_sign, fp32_rnd};

  // Stage 1: one rounded beat.
  logic              s1_valid_reg;
  logic [WORD_W-1:0] s1_value_reg;
  fmt_e              s1_fmt_reg;
  logic              s1_last_reg;
  logic              s1_advance;
  logic              in_ready_int;
  logic              accept;

  // Stage 2: packing FSM, held half and output word register.
  pack_state_e       state_reg, state_next;
  logic [HALF_W-1:0] held_reg, held_next;
  logic              out_valid_reg;
  logic [WORD_W-1:0] out_data_reg;
  logic              out_last_reg;
  logic              out_free;
  logic              load_out;
  logic [WORD_W-1:0] word_next;
  logic              last_next;

  assign out_free     = !out_valid_reg || bus.out_ready;
  assign in_ready_int = !rst && (!s1_valid_reg || s1_advance);
  assign accept       = bus.in_valid && in_ready_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_value_reg <= '0;
      s1_fmt_reg   <= FMT_FP32;
      s1_last_reg  <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_value_reg <= rounded;
      s1_fmt_reg   <= in_fmt_e;
      s1_last_reg  <= bus.in_last;
    end else if (s1_advance) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      held_reg  <= '0;
    end else begin
      state_reg <= state_next;
      held_reg  <= held_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    held_next  = held_reg;
    s1_advance = 1'b0;
    load_out   = 1'b0;
    word_next  = s1_value_reg;
    last_next  = s1_last_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (s1_valid_reg) begin
          if (s1_fmt_reg == FMT_FP32) begin
            if (out_free) begin
              load_out   = 1'b1;
              s1_advance = 1'b1;
            end
          end else if (!s1_last_reg) begin
            // Absorbing a low half never needs the output register.
            held_next  = s1_value_reg[HALF_W-1:0];
            state_next = ST_HALF;
            s1_advance = 1'b1;
          end else if (out_free) begin
            load_out   = 1'b1;
            s1_advance = 1'b1;
            word_next  = {16'h0000, s1_value_reg[HALF_W-1:0]};
          end
        end
      end
      ST_HALF: begin
        if (s1_valid_reg && out_free) begin
          load_out   = 1'b1;
          state_next = ST_EMPTY;
          if (s1_fmt_reg == FMT_BF16) begin
            word_next  = {s1_value_reg[HALF_W-1:0], held_reg};
            s1_advance = 1'b1;
          end else begin
            // Flush the lone half first; the FP32 beat waits in stage 1.
            word_next = {16'h0000, held_reg};
            last_next = 1'b0;
          end
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (load_out) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= word_next;
      out_last_reg  <= last_next;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;

endmodule

// File: tb/tb_acc_result_packer.sv
// Directed and randomized checks of acc_result_packer against an arithmetic
// rounding model and a word-order scoreboard.
module tb_acc_result_packer;
  import acc_result_packer_pkg::*;

  localparam int M = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  acc_result_packer_if #(.M_OUT_WIDTH(M)) bus ();

  acc_result_packer #(.M_OUT_WIDTH(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference rounding: integer quotient and remainder of the fraction.
  function automatic logic [31:0] ref_round(input logic sign, input logic [7:0] e,
                                            input logic [M-1:0] m, input logic bf);
    int     t;
    int     sh;
    longint q, rem, half, comb, inf;
    t = bf ? 7 : 23;
    sh = M - t;
    if (sh > 0) begin
      q    = longint'(m) >> sh;
      rem  = longint'(m) - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    end else begin
      q = longint'(m) << (-sh);
    end
    inf  = longint'(255) << t;
    comb = longint'(e) * (longint'(1) << t) + q;
    if (e == 8'd255 || comb >= inf) comb = inf;
    if (bf) return {16'h0000, sign, comb[14:0]};
    return {sign, comb[30:0]};
  endfunction

  // Scoreboard: expected {last, data} words in order, plus the held half.
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  logic        held_v = 1'b0;
  logic [15:0] held_val = '0;
  logic        stab_v = 1'b0;
  logic [31:0] stab_data;
  logic        stab_last;

  task automatic model_accept(input logic sign, input logic [7:0] e, input logic [M-1:0] m,
                              input logic bf, input logic last);
    logic [31:0] v;
    v = ref_round(sign, e, m, bf);
    if (!bf) begin
      if (held_v) exp_q.push_back({1'b0, 16'h0000, held_val});
      held_v = 1'b0;
      exp_q.push_back({last, v});
    end else if (held_v) begin
      exp_q.push_back({last, v[15:0], held_val});
      held_v = 1'b0;
    end else if (last) begin
      exp_q.push_back({1'b1, v});
    end else begin
      held_v   = 1'b1;
      held_val = v[15:0];
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
      exp_q.delete();
      stab_v = 1'b0;
    end else begin
      if (stab_v) begin
        check_val("stall_valid", bus.out_valid, 1);
        check_val("stall_data", bus.out_data, stab_data);
        check_val("stall_last", bus.out_last, stab_last);
      end
      if (bus.in_valid && bus.in_ready)
        model_accept(bus.in_sign, bus.in_exp, bus.in_mant, bus.in_fmt, bus.in_last);
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back({bus.out_last, bus.out_data});
        check_val("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check_val("sb_data", bus.out_data, e[31:0]);
          check_val("sb_last", bus.out_last, e[32]);
        end
      end
      stab_v    = bus.out_valid && !bus.out_ready;
      stab_data = bus.out_data;
      stab_last = bus.out_last;
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic send_beat(input logic sign, input logic [7:0] e, input logic [M-1:0] m,
                           input logic bf, input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_sign  = sign;
    bus.in_exp   = e;
    bus.in_mant  = m;
    bus.in_fmt   = bf;
    bus.in_last  = last;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check_val("in_ready_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] data, input logic last);
    int n;
    logic [32:0] w;
    n = 0;
    while (got_q.size() == 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (got_q.size() == 0) begin
      check_val({tag, "_timeout"}, got_q.size(), 1);
    end else begin
      w = got_q.pop_front();
      check_val({tag, "_data"}, w[31:0], data);
      check_val({tag, "_last"}, w[32], last);
    end
    @(posedge clk);
    #1;
  endtask

  logic [M-1:0] ones;
  logic         rnd_done;

  initial begin
    ones = '1;
    rnd_done = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_exp = '0;
    bus.in_mant = '0;
    bus.in_fmt = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_data", bus.out_data, 0);
    check_val("rst_out_last", bus.out_last, 0);
    check_val("rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // FP32 exact value and two-cycle latency.
    send_beat(0, EXP_BIAS[7:0], '0, 0, 0);
    @(negedge clk);
    check_val("lat_cycle1_valid", bus.out_valid, 0);
    @(negedge clk);
    check_val("lat_cycle2_valid", bus.out_valid, 1);
    expect_word("fp32_one", 32'h3F800000, 0);

    // Round-to-nearest-even ties and carries.
    send_beat(0, 8'd127, 26'h0000004, 0, 0);
    expect_word("rne_tie_even", 32'h3F800000, 0);
    send_beat(0, 8'd127, 26'h000000C, 0, 0);
    expect_word("rne_tie_odd", 32'h3F800002, 0);
    send_beat(0, 8'd127, 26'h0000005, 0, 0);
    expect_word("rne_above", 32'h3F800001, 0);
    send_beat(0, 8'd254, ones, 0, 0);
    expect_word("carry_inf", 32'h7F800000, 0);
    send_beat(0, 8'd0, ones, 0, 0);
    expect_word("denorm_promote", 32'h00800000, 0);
    send_beat(1, 8'd255, 26'h0123456, 0, 0);
    expect_word("neg_inf", 32'hFF800000, 0);

    // BF16 packing.
    send_beat(0, 8'd127, '0, 1, 0);
    send_beat(1, 8'd128, '0, 1, 1);
    expect_word("bf16_pair", 32'hC0003F80, 1);
    send_beat(0, 8'd127, '0, 1, 1);
    expect_word("bf16_single", 32'h00003F80, 1);

    // Format switch with a half held.
    send_beat(0, 8'd127, '0, 1, 0);
    send_beat(0, 8'd127, '0, 0, 0);
    expect_word("switch_half", 32'h00003F80, 0);
    expect_word("switch_fp32", 32'h3F800000, 0);

    // Backpressure: two beats accepted, third blocked.
    bus.out_ready = 1'b0;
    send_beat(0, 8'd127, '0, 0, 0);
    send_beat(0, 8'd128, '0, 0, 0);
    bus.in_valid = 1'b1;
    bus.in_exp = 8'd129;
    repeat (3) begin
      @(negedge clk);
      check_val("bp_in_ready_low", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send_beat(0, 8'd129, '0, 0, 0);
    expect_word("bp_word0", 32'h3F800000, 0);
    expect_word("bp_word1", 32'h40000000, 0);
    expect_word("bp_word2", 32'h40800000, 0);

    // Reset with a held half discards it.
    send_beat(0, 8'd127, '0, 1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_in_ready", bus.in_ready, 0);
    check_val("mid_rst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("mid_rst_ready_after", bus.in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check_val("mid_rst_no_word", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    send_beat(0, 8'd130, '0, 1, 0);
    send_beat(0, 8'd127, '0, 1, 1);
    expect_word("after_rst_pair", 32'h3F804100, 1);

    // Randomized traffic with random backpressure.
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic        s, bf, lst;
          logic [7:0]  e;
          logic [31:0] r;
          logic [M-1:0] m;
          int sel;
          s = 1'($urandom_range(0, 1));
          bf = 1'($urandom_range(0, 1));
          lst = ($urandom_range(0, 99) < 20);
          sel = $urandom_range(0, 9);
          e = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd254 : (sel == 2) ? 8'd255
                                : 8'($urandom_range(1, 253));
          r = $urandom;
          m = r[M-1:0];
          sel = $urandom_range(0, 5);
          if (sel == 0) m = ones;
          else if (sel == 1) m = {m[M-1:3], 3'b100};
          else if (sel == 2) m = {m[M-1:19], 1'b1, 18'h0};
          send_beat(s, e, m, bf, lst);
          if ($urandom_range(0, 9) == 0) begin
            @(posedge clk); #1;
          end
        end
        send_beat(0, 8'd127, '0, 1, 1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 99) < 70);
        end
        bus.out_ready = 1'b1;
      end
    join

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    check_val("drain_empty", exp_q.size(), 0);
    check_val("drain_no_held", held_v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
